// File: rtl/cam_stream_gen.sv
// cam_stream_gen: synthetic OV7670-style VSYNC/HREF/pixel frame source.
// Generates one pixel per clock with selectable test patterns.
// Optional feature: define CAM_GEN_CHECKER_EN to make PATTERN=3 emit an
// 8x8 checkerboard; otherwise PATTERN=3 is solid 8'h00.
module cam_stream_gen #(
    parameter int H_ACTIVE   = 176,
    parameter int V_ACTIVE   = 144,
    parameter int H_BLANK    = 16,
    parameter int VS_LINES   = 3,
    parameter int V_BACK     = 17,
    parameter int V_FRONT    = 10,
    parameter int BAR_HEIGHT = 48
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic [1:0] PATTERN,
    output logic [7:0] PIXEL_OUT,
    output logic       HREF,
    output logic       VSYNC,
    output logic       FRAME_DONE,
    output logic       BUSY
);

    localparam int L  = H_ACTIVE + H_BLANK;
    localparam int XW = $clog2(L);
    localparam int YW = $clog2(VS_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_BACK,
        S_ACTIVE,
        S_FRONT
    } state_t;

    state_t          state, n_state;
    logic [XW-1:0]   x, n_x;
    logic [YW-1:0]   y, n_y;
    logic [1:0]      pat, n_pat;
    int              y_len;
    logic [7:0]      n_pix;
    logic            n_href;
    logic            n_done;

    // Next position in the frame: x wraps every line, y counts lines within
    // the current state and restarts on each state change.
    always_comb begin
        n_state = state;
        n_x     = x;
        n_y     = y;
        case (state)
            S_SYNC:   y_len = VS_LINES;
            S_BACK:   y_len = V_BACK;
            S_ACTIVE: y_len = V_ACTIVE;
            S_FRONT:  y_len = V_FRONT;
            default:  y_len = 1;
        endcase
        if (state == S_IDLE) begin
            if (ENABLE) begin
                n_state = S_SYNC;
            end
            n_x = '0;
            n_y = '0;
        end else if (int'(x) != L - 1) begin
            n_x = x + 1'b1;
        end else begin
            n_x = '0;
            if (int'(y) != y_len - 1) begin
                n_y = y + 1'b1;
            end else begin
                n_y = '0;
                case (state)
                    S_SYNC:   n_state = S_BACK;
                    S_BACK:   n_state = S_ACTIVE;
                    S_ACTIVE: n_state = S_FRONT;
                    S_FRONT:  n_state = ENABLE ? S_SYNC : S_IDLE;
                    default:  n_state = S_IDLE;
                endcase
            end
        end
    end

    // Output values for the upcoming cycle, derived from the next position so
    // that every output can be a plain register with no input-to-output path.
    always_comb begin
        n_pat  = (n_state == S_SYNC && state != S_SYNC) ? PATTERN : pat;
        n_href = (n_state == S_ACTIVE) && (int'(n_x) < H_ACTIVE);
        n_done = (n_state == S_FRONT) && (int'(n_y) == V_FRONT - 1) &&
                 (int'(n_x) == L - 1);
        n_pix  = '0;
        if (n_href) begin
            case (n_pat)
                2'd1: n_pix = 8'hE0;
                2'd2: begin
                    if (int'(n_y) < BAR_HEIGHT)
                        n_pix = 8'h00;
                    else if (int'(n_y) < 2 * BAR_HEIGHT)
                        n_pix = 8'hE0;
                    else
                        n_pix = 8'hFF;
                end
`ifdef CAM_GEN_CHECKER_EN
                2'd3: n_pix = (n_x[3] ^ n_y[3]) ? 8'hFF : 8'h00;
`endif
                default: n_pix = 8'h00;
            endcase
        end
    end

    // Frame FSM, counters, latched pattern and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= S_IDLE;
            x          <= '0;
            y          <= '0;
            pat        <= '0;
            PIXEL_OUT  <= '0;
            HREF       <= 1'b0;
            VSYNC      <= 1'b0;
            FRAME_DONE <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            state      <= n_state;
            x          <= n_x;
            y          <= n_y;
            pat        <= n_pat;
            PIXEL_OUT  <= n_pix;
            HREF       <= n_href;
            VSYNC      <= (n_state == S_SYNC);
            FRAME_DONE <= n_done;
            BUSY       <= (n_state != S_IDLE);
        end
    end

endmodule

// File: tb/tb_cam_stream_gen.sv
// Bench for cam_stream_gen: one default-size instance for the full-frame
// figures, one small instance for randomized ENABLE/PATTERN/RESET traffic.
module tb_cam_stream_gen;

    // Default geometry (instance A)
    localparam int HA_A = 176, HB_A = 16, VA_A = 144, VS_A = 3, VB_A = 17, VF_A = 10, BAR_A = 48;
    localparam int FA   = (VS_A + VB_A + VA_A + VF_A) * (HA_A + HB_A);
    // Small geometry (instance B)
    localparam int HA_B = 24, HB_B = 6, VA_B = 20, VS_B = 2, VB_B = 3, VF_B = 2, BAR_B = 6;
    localparam int FB   = (VS_B + VB_B + VA_B + VF_B) * (HA_B + HB_B);

`ifdef CAM_GEN_CHECKER_EN
    localparam int CHK_ON = 1;
`else
    localparam int CHK_ON = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, rst_b, en_b;
    logic [1:0] pat_a, pat_b;
    logic [7:0] pix_a, pix_b;
    logic       href_a, vs_a, fd_a, busy_a;
    logic       href_b, vs_b, fd_b, busy_b;

    cam_stream_gen dut_a (
        .CLK(clk), .RESET(rst_a), .ENABLE(en_a), .PATTERN(pat_a),
        .PIXEL_OUT(pix_a), .HREF(href_a), .VSYNC(vs_a), .FRAME_DONE(fd_a), .BUSY(busy_a)
    );

    cam_stream_gen #(
        .H_ACTIVE(HA_B), .V_ACTIVE(VA_B), .H_BLANK(HB_B), .VS_LINES(VS_B),
        .V_BACK(VB_B), .V_FRONT(VF_B), .BAR_HEIGHT(BAR_B)
    ) dut_b (
        .CLK(clk), .RESET(rst_b), .ENABLE(en_b), .PATTERN(pat_b),
        .PIXEL_OUT(pix_b), .HREF(href_b), .VSYNC(vs_b), .FRAME_DONE(fd_b), .BUSY(busy_b)
    );

    int tests = 0;
    int fails = 0;
    logic chk = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {pixel, href, vsync, frame_done, busy} from the cycle offset c
    // inside a running frame.
    function automatic logic [11:0] model_out(input int ha, input int hb, input int va,
                                              input int vs, input int vb, input int vf,
                                              input int bar, input logic run,
                                              input int c, input int pat);
        int   l;
        int   line;
        int   x;
        int   al;
        logic act;
        logic [7:0] p;
        l    = ha + hb;
        line = c / l;
        x    = c % l;
        al   = line - vs - vb;
        p    = 8'h00;
        if (!run) return 12'h000;
        act = (al >= 0) && (al < va) && (x < ha);
        if (act) begin
            if (pat == 1) p = 8'hE0;
            else if (pat == 2) p = (al < bar) ? 8'h00 : ((al < 2 * bar) ? 8'hE0 : 8'hFF);
            else if (pat == 3 && CHK_ON == 1) p = (((x / 8) % 2) != ((al / 8) % 2)) ? 8'hFF : 8'h00;
        end
        return {p, act, (line < vs), (c == (vs + vb + va + vf) * l - 1), 1'b1};
    endfunction

    // Reference frame position: running flag, cycle offset, latched pattern.
    logic run_a, run_b;
    int   c_a, c_b, mp_a, mp_b;

    always @(posedge clk or posedge rst_a) begin
        if (rst_a) run_a <= 1'b0;
        else if (!run_a) begin
            if (en_a) begin run_a <= 1'b1; c_a <= 0; mp_a <= int'(pat_a); end
        end else if (c_a == FA - 1) begin
            if (en_a) begin c_a <= 0; mp_a <= int'(pat_a); end
            else run_a <= 1'b0;
        end else c_a <= c_a + 1;
    end

    always @(posedge clk or posedge rst_b) begin
        if (rst_b) run_b <= 1'b0;
        else if (!run_b) begin
            if (en_b) begin run_b <= 1'b1; c_b <= 0; mp_b <= int'(pat_b); end
        end else if (c_b == FB - 1) begin
            if (en_b) begin c_b <= 0; mp_b <= int'(pat_b); end
            else run_b <= 1'b0;
        end else c_b <= c_b + 1;
    end

    // Every-cycle comparison of both instances against the reference.
    always @(negedge clk) begin
        if (chk) begin
            if (!rst_a)
                check("out_a", int'({pix_a, href_a, vs_a, fd_a, busy_a}),
                      int'(model_out(HA_A, HB_A, VA_A, VS_A, VB_A, VF_A, BAR_A, run_a, c_a, mp_a)));
            if (!rst_b)
                check("out_b", int'({pix_b, href_b, vs_b, fd_b, busy_b}),
                      int'(model_out(HA_B, HB_B, VA_B, VS_B, VB_B, VF_B, BAR_B, run_b, c_b, mp_b)));
        end
    end

    // Full default frame, PATTERN=2, ENABLE dropped right after start.
    task automatic big_frame();
        int nv = 0, nh = 0, n00 = 0, ne0 = 0, nff = 0, nrise = 0, nfd = 0;
        int first_h = -1, fd_idx = -1, busy_after = -1, vs0 = 0, busy0 = 0;
        logic prev = 1'b0;
        @(negedge clk);
        pat_a = 2'd2;
        en_a  = 1'b1;
        @(negedge clk);
        en_a  = 1'b0;
        pat_a = 2'd1;
        for (int i = 0; i < FA + 4; i++) begin
            if (i == 0) begin vs0 = int'(vs_a); busy0 = int'(busy_a); end
            if (vs_a) nv++;
            if (href_a) begin
                nh++;
                if (pix_a == 8'h00) n00++;
                else if (pix_a == 8'hE0) ne0++;
                else if (pix_a == 8'hFF) nff++;
                if (!prev) nrise++;
                if (first_h < 0) first_h = i;
            end
            if (fd_a) begin nfd++; fd_idx = i; end
            if (i == FA) busy_after = int'(busy_a);
            prev = href_a;
            @(negedge clk);
        end
        check("a_vsync_start", vs0, 1);
        check("a_busy_start", busy0, 1);
        check("a_vsync_cycles", nv, 576);
        check("a_href_pulses", nrise, 144);
        check("a_href_cycles", nh, 25344);
        check("a_pix_00", n00, 8448);
        check("a_pix_e0", ne0, 8448);
        check("a_pix_ff", nff, 8448);
        check("a_first_href", first_h, 3840);
        check("a_frame_done_idx", fd_idx, 33407);
        check("a_frame_done_cnt", nfd, 1);
        check("a_busy_after", busy_after, 0);
    endtask

    // Small instance: directed pattern-3 frame plus back-to-back spacing,
    // reset during ACTIVE, then randomized traffic.
    task automatic small_frames();
        int waited;
        @(negedge clk);
        pat_b = 2'd3;
        en_b  = 1'b1;
        @(negedge clk);
        pat_b = 2'd0;
        for (int i = 0; i <= FB; i++) begin
            case (i)
                0:   check("b_vs_0", int'(vs_b), 1);
                59:  check("b_vs_59", int'(vs_b), 1);
                60:  check("b_vs_60", int'(vs_b), 0);
                149: check("b_href_149", int'(href_b), 0);
                150: check("b_l0_x0", int'({href_b, pix_b}), 'h100);
                157: check("b_l0_x7", int'(pix_b), 'h00);
                158: check("b_l0_x8", int'(pix_b), CHK_ON ? 'hFF : 'h00);
                165: check("b_l0_x15", int'(pix_b), CHK_ON ? 'hFF : 'h00);
                390: check("b_l8_x0", int'(pix_b), CHK_ON ? 'hFF : 'h00);
                809: check("b_fd_809", int'({vs_b, fd_b}), 1);
                810: check("b_vs_810", int'(vs_b), 1);
                default: ;
            endcase
            @(negedge clk);
        end
        en_b = 1'b0;
        waited = 0;
        while (busy_b && waited < 2 * FB) begin @(negedge clk); waited++; end
        check("b_idle_after", int'(busy_b), 0);

        // Reset in the middle of ACTIVE
        pat_b = 2'd1;
        en_b  = 1'b1;
        waited = 0;
        while (!(href_b && run_b && c_b >= 10 * (HA_B + HB_B) + 150) && waited < 2 * FB) begin
            @(negedge clk);
            waited++;
        end
        check("b_reached_active", int'(href_b), 1);
        #2 rst_b = 1'b1;
        #1 check("b_rst_outs", int'({pix_b, href_b, vs_b, fd_b, busy_b}), 0);
        @(negedge clk);
        #2 rst_b = 1'b0;
        @(negedge clk);
        check("b_restart_vs", int'(vs_b), 1);
        repeat (150) @(negedge clk);
        check("b_restart_l0", int'({href_b, pix_b}), 'h1E0);

        // Randomized ENABLE holds, per-cycle PATTERN churn, occasional resets
        for (int it = 0; it < 20; it++) begin
            en_b = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 1500)) begin
                @(negedge clk);
                pat_b = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 5) == 0) begin
                #2 rst_b = 1'b1;
                @(negedge clk);
                #2 rst_b = 1'b0;
            end
        end
        en_b = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        en_a  = 1'b0; en_b  = 1'b0;
        pat_a = 2'd0; pat_b = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_a_outs", int'({pix_a, href_a, vs_a, fd_a, busy_a}), 0);
        check("rst_b_outs", int'({pix_b, href_b, vs_b, fd_b, busy_b}), 0);
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;
        chk   = 1'b1;
        fork
            big_frame();
            small_frames();
        join
        repeat (2 * FB) @(negedge clk);
        check("a_stays_idle", int'({vs_a, busy_a}), 0);
        check("b_stays_idle", int'({vs_b, busy_b}), 0);
        chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
